qos_csr_initiator: RTL

// - Initiator side of the QoS CSR bus (0xBC0-0xBDF). Turns core CSR ops (READ/WRITE/SET/CLEAR) into bus transactions.
// - Sits between the core CSR execute stage and the QoS CSR register file.
// - SET/CLEAR run as read-modify-write. Completion carries the old value, error and timeout status.

---
 rtl/qos_csr_initiator.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/qos_csr_initiator.sv
// qos_csr_initiator: initiator side of the QoS CSR bus. Turns core CSR
// READ/WRITE/SET/CLEAR ops into bus reads, writes and read-modify-writes,
// and returns one completion carrying the old value plus error/timeout status.
module qos_csr_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [11:0] ADDR_LO        = 12'hBC0,
    parameter logic [11:0] ADDR_HI        = 12'hBDF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [11:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        done_valid_o,
    input  logic        done_ready_i,
    output logic [31:0] done_rdata_o,
    output logic        done_error_o,
    output logic        done_timeout_o,
    output logic        csr_req_valid_o,
    input  logic        csr_req_ready_i,
    output logic [11:0] csr_addr_o,
    output logic        csr_write_o,
    output logic [31:0] csr_wdata_o,
    input  logic        csr_rsp_valid_i,
    input  logic [31:0] csr_rdata_i,
    input  logic        csr_error_i,
    output logic [7:0]  err_count_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    localparam int unsigned        TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]         state_q;
    logic [1:0]         op_q;
    logic [11:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               error_q;
    logic               timeout_q;
    logic [TIMER_W-1:0] timer_q;
    logic [7:0]         err_count_q;

    logic               cmd_illegal;
    logic               wait_expired;
    logic               err_event;
    logic [31:0]        rmw_value;

    assign cmd_illegal  = (cmd_addr_i < ADDR_LO) || (cmd_addr_i > ADDR_HI);
    assign wait_expired = (timer_q == TIMER_LAST);

    // wdata_q holds the SET/CLEAR mask until the old value arrives
    assign rmw_value = (op_q == OP_SET) ? (csr_rdata_i | wdata_q)
                                        : (csr_rdata_i & ~wdata_q);

    // an errored completion is decided on exactly one of these DONE-entry paths
    assign err_event = (state_q == IDLE    && cmd_valid_i && cmd_illegal) ||
                       (state_q == RD_WAIT && (csr_error_i || (!csr_rsp_valid_i && wait_expired))) ||
                       (state_q == WR_WAIT && csr_error_i);

    // transaction sequencing: latch the command, run the bus phases, hold the completion
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= 2'b00;
            addr_q    <= 12'h000;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q      <= cmd_op_i;
                        addr_q    <= cmd_addr_i;
                        wdata_q   <= cmd_wdata_i;
                        rdata_q   <= 32'h0;
                        error_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        if (cmd_illegal) begin
                            error_q <= 1'b1;
                            state_q <= DONE;
                        end else if (cmd_op_i == OP_WRITE) begin
                            state_q <= WR_REQ;
                        end else begin
                            state_q <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (csr_req_ready_i) begin
                        timer_q <= '0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (csr_error_i) begin
                        error_q <= 1'b1;
                        rdata_q <= 32'h0;
                        state_q <= DONE;
                    end else if (csr_rsp_valid_i) begin
                        rdata_q <= csr_rdata_i;
                        if (op_q == OP_READ || wdata_q == 32'h0) begin
                            state_q <= DONE;
                        end else begin
                            wdata_q <= rmw_value;
                            state_q <= WR_REQ;
                        end
                    end else if (wait_expired) begin
                        error_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                WR_REQ: begin
                    if (csr_req_ready_i) begin
                        state_q <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (csr_error_i) begin
                        error_q <= 1'b1;
                        rdata_q <= 32'h0;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    if (done_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // errored-completion counter, bumped on DONE entry and saturating at 255
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_count_q <= 8'd0;
        end else if (err_event && err_count_q != 8'hFF) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign cmd_ready_o     = (state_q == IDLE);
    assign csr_req_valid_o = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign csr_write_o     = (state_q == WR_REQ);
    assign csr_addr_o      = csr_req_valid_o ? addr_q : 12'h000;
    assign csr_wdata_o     = csr_write_o ? wdata_q : 32'h0;
    assign done_valid_o    = (state_q == DONE);
    assign done_rdata_o    = done_valid_o ? rdata_q : 32'h0;
    assign done_error_o    = done_valid_o & error_q;
    assign done_timeout_o  = done_valid_o & timeout_q;
    assign err_count_o     = err_count_q;

endmodule
